// File: rtl/psx_multi_poller.sv
// -----------------------------------------------------------------------------
// psx_multi_poller
//   Round-robin poller for up to four PSX controllers sharing one
//   psx_clk/cmd/data/ack bus, with one active-low attention line per port.
//   Each frame sends 0x01, 0x42, 0x00...; the ID byte returned in byte 1 sizes
//   the frame (3 + N bytes). A missing ACK aborts the frame. Button/stick state
//   of a port is published in a single cycle at the end of a good frame.
//
// Optional feature (compile-time macro PSX_FRAME_CHECK_EN):
//   when defined, a frame is also rejected unless byte 2 is 0x5A and ID[7:4]
//   is 0x4 or 0x7.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   data         shared controller data line (sampled as psx_clk rises)
//   ack          shared controller ACK, active-low
//   psx_clk      bus clock, idle high
//   cmd          command line, idle high, LSB first
//   att          per-port attention, active-low, at most one low
//   button_state per port {byte3,byte4}, active-low as received
//   stick_state  per port {rx,ry,lx,ly}
//   present      1 = last frame on that port completed
//   mode_id      last good ID byte per port
//   frame_done   one-cycle pulse at the end of every frame
//   frame_port   port index of the frame that just ended
// -----------------------------------------------------------------------------
module psx_multi_poller #(
    parameter int NUM_PORTS   = 2,
    parameter int HALF_BIT    = 4,
    parameter int BOOT_TIME   = 4000000,
    parameter int ATT_SETUP   = 40,
    parameter int BYTE_GAP    = 14,
    parameter int ACK_TIMEOUT = 120,
    parameter int FRAME_GAP   = 250
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data,
    input  logic                   ack,
    output logic                   psx_clk,
    output logic                   cmd,
    output logic [NUM_PORTS-1:0]   att,
    output logic [16*NUM_PORTS-1:0] button_state,
    output logic [32*NUM_PORTS-1:0] stick_state,
    output logic [NUM_PORTS-1:0]   present,
    output logic [8*NUM_PORTS-1:0] mode_id,
    output logic                   frame_done,
    output logic [1:0]             frame_port
);

    // Port selection happens on the transition into S_SETUP, so att falls on
    // the same edge that leaves BOOT/DESELECT.
    typedef enum logic [2:0] {
        S_BOOT, S_SETUP, S_SHIFT, S_ACK_WAIT, S_GAP, S_TAIL, S_DESELECT
    } state_t;

    localparam logic [31:0] BOOT_LAST  = 32'(BOOT_TIME - 1);
    localparam logic [31:0] SETUP_LAST = 32'(ATT_SETUP - 1);
    localparam logic [31:0] HALF_LAST  = 32'(HALF_BIT - 1);
    localparam logic [31:0] GAP_LAST   = 32'(BYTE_GAP - 1);
    localparam logic [31:0] ACK_LAST   = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0] FRAME_LAST = 32'(FRAME_GAP - 1);

    state_t                  state_q;
    logic [31:0]             cnt_q;
    logic [2:0]              bit_q;
    logic [3:0]              byte_q;
    logic [1:0]              port_q;
    logic                    psx_clk_q, cmd_q;
    logic [NUM_PORTS-1:0]    att_q, present_q;
    logic [16*NUM_PORTS-1:0] button_q;
    logic [32*NUM_PORTS-1:0] stick_q;
    logic [8*NUM_PORTS-1:0]  mode_q;
    logic                    frame_done_q;
    logic [1:0]              frame_port_q;

    // Receive shift register and per-frame shadow bytes.
    logic [7:0]  rx_q, id_q, sig_q, b3_q, b4_q;
    logic [31:0] stk_q;

    logic [3:0] n_d;
    logic [7:0] tx_d;
    logic [1:0] port_nx_d;
    logic       last_d, half_end_d, sample_d, byte_end_d, fail_d, good_end_d, ok_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        // N = 2*ID[3:0] clamped to 6, with ID[3:0]=0 treated as N=2.
        n_d = 4'd6;
        if (id_q[3:0] == 4'd0)     n_d = 4'd2;
        else if (id_q[3:0] < 4'd3) n_d = {id_q[2:0], 1'b0};
        // id_q is stale during bytes 0/1, but 2+N >= 4 can never match them.
        last_d = (byte_q == 4'd2 + n_d);

        tx_d = 8'h00;
        if (byte_q == 4'd0)      tx_d = 8'h01;
        else if (byte_q == 4'd1) tx_d = 8'h42;

        port_nx_d  = (port_q == 2'(NUM_PORTS - 1)) ? 2'd0 : port_q + 2'd1;
        half_end_d = (state_q == S_SHIFT) && (cnt_q == HALF_LAST);
        sample_d   = half_end_d && !psx_clk_q;
        byte_end_d = half_end_d && psx_clk_q && (bit_q == 3'd7);
        fail_d     = (state_q == S_ACK_WAIT) && ack && (cnt_q == ACK_LAST);
        good_end_d = (state_q == S_TAIL) && (cnt_q == GAP_LAST);

`ifdef PSX_FRAME_CHECK_EN
        ok_d = (sig_q == 8'h5A) && ((id_q[7:4] == 4'h4) || (id_q[7:4] == 4'h7));
`else
        ok_d = 1'b1;
`endif
    end

    // NOTE: the shadow registers carry no reset: each field is rewritten by
    // the current frame before it can ever be published.
    always_ff @(posedge clk) begin
        if (sample_d) rx_q <= {data, rx_q[7:1]};
        if (byte_end_d) begin
            case (byte_q)
                4'd1:    id_q          <= rx_q;
                4'd2:    sig_q         <= rx_q;
                4'd3:    b3_q          <= rx_q;
                4'd4:    b4_q          <= rx_q;
                4'd5:    stk_q[31:24]  <= rx_q;
                4'd6:    stk_q[23:16]  <= rx_q;
                4'd7:    stk_q[15:8]   <= rx_q;
                4'd8:    stk_q[7:0]    <= rx_q;
                default: ;
            endcase
        end
    end

    // NOTE: state is written with non-blocking assignments only, so every
    // right-hand side sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BOOT;
            cnt_q        <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            port_q       <= '0;
            psx_clk_q    <= 1'b1;
            cmd_q        <= 1'b1;
            att_q        <= '1;
            button_q     <= {NUM_PORTS{16'hFFFF}};
            stick_q      <= {NUM_PORTS{32'h8080_8080}};
            present_q    <= '0;
            mode_q       <= '0;
            frame_done_q <= 1'b0;
            frame_port_q <= '0;
        end else begin
            cnt_q        <= cnt_q + 32'd1;
            frame_done_q <= 1'b0;
            case (state_q)
                S_BOOT: if (cnt_q == BOOT_LAST) begin
                    state_q <= S_SETUP;
                    cnt_q   <= '0;
                    byte_q  <= '0;
                    att_q   <= ~(NUM_PORTS'(1) << port_q);
                end
                S_SETUP, S_GAP: begin
                    if ((state_q == S_SETUP && cnt_q == SETUP_LAST) ||
                        (state_q == S_GAP   && cnt_q == GAP_LAST)) begin
                        state_q   <= S_SHIFT;
                        cnt_q     <= '0;
                        bit_q     <= '0;
                        psx_clk_q <= 1'b0;
                        cmd_q     <= tx_d[0];
                    end
                end
                S_SHIFT: if (half_end_d) begin
                    cnt_q <= '0;
                    if (!psx_clk_q) begin
                        psx_clk_q <= 1'b1;
                    end else if (bit_q != 3'd7) begin
                        bit_q     <= bit_q + 3'd1;
                        psx_clk_q <= 1'b0;
                        cmd_q     <= tx_d[bit_q + 3'd1];
                    end else begin
                        cmd_q   <= 1'b1;
                        byte_q  <= byte_q + 4'd1;
                        state_q <= last_d ? S_TAIL : S_ACK_WAIT;
                    end
                end
                S_ACK_WAIT: if (!ack) begin
                    state_q <= S_GAP;
                    cnt_q   <= '0;
                end
                S_TAIL: ;
                S_DESELECT: if (cnt_q == FRAME_LAST) begin
                    port_q  <= port_nx_d;
                    att_q   <= ~(NUM_PORTS'(1) << port_nx_d);
                    state_q <= S_SETUP;
                    cnt_q   <= '0;
                    byte_q  <= '0;
                end
                default: state_q <= S_BOOT;
            endcase

            // Frame end (good or timed out): overrides the case above.
            if (fail_d || good_end_d) begin
                state_q      <= S_DESELECT;
                cnt_q        <= '0;
                att_q        <= '1;
                frame_done_q <= 1'b1;
                frame_port_q <= port_q;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (p == int'(port_q)) begin
                        if (good_end_d && ok_d) begin
                            button_q[16*p +: 16] <= {b3_q, b4_q};
                            mode_q[8*p +: 8]     <= id_q;
                            stick_q[32*p +: 32]  <= (n_d == 4'd6) ? stk_q : 32'h8080_8080;
                            present_q[p]         <= 1'b1;
                        end else begin
                            button_q[16*p +: 16] <= 16'hFFFF;
                            stick_q[32*p +: 32]  <= 32'h8080_8080;
                            present_q[p]         <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign psx_clk      = psx_clk_q;
    assign cmd          = cmd_q;
    assign att          = att_q;
    assign button_state = button_q;
    assign stick_state  = stick_q;
    assign present      = present_q;
    assign mode_id      = mode_q;
    assign frame_done   = frame_done_q;
    assign frame_port   = frame_port_q;

endmodule

// File: tb/tb_psx_multi_poller.sv
// -----------------------------------------------------------------------------
// tb_psx_multi_poller
//   Directed bench for psx_multi_poller (NUM_PORTS=2, BOOT_TIME=100). A simple
//   controller model answers on whichever port has att low, returns a per-port
//   byte table, ACKs a programmable number of bytes and logs the cmd bytes.
// -----------------------------------------------------------------------------
module tb_psx_multi_poller;

    localparam int HALF_BIT    = 4;
    localparam int BOOT_TIME   = 100;
    localparam int ACK_TIMEOUT = 120;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        data = 1'b1;
    logic        ack  = 1'b1;
    logic        psx_clk, cmd, frame_done;
    logic [1:0]  att, present, frame_port;
    logic [31:0] button_state;
    logic [63:0] stick_state;
    logic [15:0] mode_id;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    psx_multi_poller #(
        .NUM_PORTS(2), .HALF_BIT(HALF_BIT), .BOOT_TIME(BOOT_TIME), .ATT_SETUP(40),
        .BYTE_GAP(14), .ACK_TIMEOUT(ACK_TIMEOUT), .FRAME_GAP(250)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .ack(ack),
        .psx_clk(psx_clk), .cmd(cmd), .att(att),
        .button_state(button_state), .stick_state(stick_state),
        .present(present), .mode_id(mode_id),
        .frame_done(frame_done), .frame_port(frame_port)
    );

    always #5 clk = ~clk;

    // ---------------- controller model ----------------
    logic [7:0] resp [2][9];
    int         ack_n [2];
    logic [7:0] cmd_log [16];
    int         ncmd = 0;

    initial begin
        int   mbit, mbyte, ack_dly, ack_hold, sel;
        logic pclk_prev, idle_prev;
        logic [7:0] cbyte;
        mbit = 0; mbyte = 0; ack_dly = 0; ack_hold = 0; sel = 0;
        pclk_prev = 1'b1; idle_prev = 1'b1; cbyte = 8'h00;
        forever begin
            @(negedge clk);
            if (ack_dly > 0) begin
                ack_dly--;
                if (ack_dly == 0) begin ack = 1'b0; ack_hold = 2; end
            end else if (ack_hold > 0) begin
                ack_hold--;
                if (ack_hold == 0) ack = 1'b1;
            end
            if (att === 2'b11 || $isunknown(att)) begin
                mbit = 0; mbyte = 0; data = 1'b1; idle_prev = 1'b1; pclk_prev = 1'b1;
            end else begin
                sel = att[0] ? 1 : 0;
                if (idle_prev) ncmd = 0;
                idle_prev = 1'b0;
                if (!psx_clk && pclk_prev)
                    data = (mbyte < 9) ? resp[sel][mbyte][mbit] : 1'b1;
                if (psx_clk && !pclk_prev) begin
                    cbyte[mbit] = cmd;
                    if (mbit == 7) begin
                        if (ncmd < 16) cmd_log[ncmd] = cbyte;
                        ncmd++;
                        if (mbyte < ack_n[sel]) ack_dly = 8;
                        mbit = 0;
                        mbyte++;
                    end else begin
                        mbit++;
                    end
                end
                pclk_prev = psx_clk;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_psx_clk"}, 64'(psx_clk), 64'h1);
        check({pfx, "_cmd"}, 64'(cmd), 64'h1);
        check({pfx, "_att"}, 64'(att), 64'h3);
        check({pfx, "_button"}, 64'(button_state), 64'hFFFF_FFFF);
        check({pfx, "_stick"}, stick_state, 64'h8080_8080_8080_8080);
        check({pfx, "_present"}, 64'(present), 64'h0);
        check({pfx, "_mode"}, 64'(mode_id), 64'h0);
        check({pfx, "_frame_done"}, 64'(frame_done), 64'h0);
        check({pfx, "_frame_port"}, 64'(frame_port), 64'h0);
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin got = 1'b1; break; end
        end
    endtask

    task automatic wait_att_low(input int p, input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (att[p] === 1'b0) begin got = 1'b1; break; end
        end
    endtask

    task automatic count_rises(input int n, input int budget, output bit got);
        int   r;
        logic prev;
        r = 0; prev = psx_clk; got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (psx_clk === 1'b1 && prev === 1'b0) r++;
            prev = psx_clk;
            if (r == n) begin got = 1'b1; break; end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit         ok;
        int         c, fd;
        logic       exp_p0;
        logic [15:0] exp_b0;
        logic [7:0]  exp_m0;

        resp[0] = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        resp[1] = '{8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40};
        ack_n[0] = 4;
        ack_n[1] = 8;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;

        // First att[0] fall exactly BOOT_TIME cycles after reset release.
        c = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (att[0] === 1'b0) begin c = k; break; end
        end
        check("boot_len", 64'(c), 64'(BOOT_TIME));
        check("boot_att", 64'(att), 64'h2);

        // Port 0 digital frame, ID 0x41.
        wait_done(3000, ok);
        check("p0_done_seen", 64'(ok), 64'h1);
        check("p0_frame_port", 64'(frame_port), 64'h0);
        check("p0_button", 64'(button_state[15:0]), 64'hFEFF);
        check("p0_button_p1", 64'(button_state[31:16]), 64'hFFFF);
        check("p0_stick", 64'(stick_state[31:0]), 64'h8080_8080);
        check("p0_present", 64'(present), 64'h1);
        check("p0_mode", 64'(mode_id[7:0]), 64'h41);
        check("p0_att_idle", 64'(att), 64'h3);
        check("p0_ncmd", 64'(ncmd), 64'd5);
        check("p0_cmd0", 64'(cmd_log[0]), 64'h01);
        check("p0_cmd1", 64'(cmd_log[1]), 64'h42);
        check("p0_cmd4", 64'(cmd_log[4]), 64'h00);
        @(negedge clk);
        check("p0_done_pulse", 64'(frame_done), 64'h0);

        // Port 1 analog frame, ID 0x73.
        wait_done(3000, ok);
        check("p1_done_seen", 64'(ok), 64'h1);
        check("p1_frame_port", 64'(frame_port), 64'h1);
        check("p1_stick", 64'(stick_state[63:32]), 64'h1020_3040);
        check("p1_button", 64'(button_state[31:16]), 64'hFFFF);
        check("p1_present", 64'(present), 64'h3);
        check("p1_mode", 64'(mode_id[15:8]), 64'h73);
        check("p1_p0_kept", 64'(button_state[15:0]), 64'hFEFF);
        check("p1_ncmd", 64'(ncmd), 64'd9);
        for (int i = 0; i < 9; i++)
            check($sformatf("p1_cmd%0d", i), 64'(cmd_log[i]),
                  (i == 0) ? 64'h01 : (i == 1) ? 64'h42 : 64'h00);

        // Port 1 controller will stop ACKing after byte 1.
        ack_n[1] = 1;
        wait_done(3000, ok);
        check("wrap_done_seen", 64'(ok), 64'h1);
        check("wrap_frame_port", 64'(frame_port), 64'h0);

        wait_att_low(1, 1000, ok);
        check("to_att_low", 64'(ok), 64'h1);
        count_rises(16, 2000, ok);
        check("to_rises", 64'(ok), 64'h1);
        c = 0;
        for (int k = 1; k <= 500; k++) begin
            @(posedge clk); #1;
            if (att[1] === 1'b1) begin c = k; break; end
        end
        // Last rise of byte 1 is HALF_BIT cycles before the byte ends.
        check("to_latency", 64'(c), 64'(HALF_BIT + ACK_TIMEOUT));
        check("to_frame_done", 64'(frame_done), 64'h1);
        check("to_frame_port", 64'(frame_port), 64'h1);
        check("to_present", 64'(present), 64'h1);
        check("to_button", 64'(button_state[31:16]), 64'hFFFF);
        check("to_stick", 64'(stick_state[63:32]), 64'h8080_8080);
        check("to_mode_kept", 64'(mode_id[15:8]), 64'h73);
        check("to_p0_button", 64'(button_state[15:0]), 64'hFEFF);
        check("to_p0_mode", 64'(mode_id[7:0]), 64'h41);

        // Reset in the low phase of byte 4, bit 1 of port 0.
        wait_att_low(0, 1000, ok);
        check("mr_att_low", 64'(ok), 64'h1);
        count_rises(33, 3000, ok);
        check("mr_rises", 64'(ok), 64'h1);
        repeat (5) @(posedge clk);
        #1;
        check("mr_pre_psx_clk", 64'(psx_clk), 64'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("mr");

        resp[0][2] = 8'h00;
        resp[1] = '{8'hFF, 8'h40, 8'h5A, 8'hAB, 8'hCD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        ack_n[1] = 4;
        rst = 1'b0;

        c = 0; fd = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (frame_done === 1'b1) fd++;
            if (att[0] === 1'b0) begin c = k; break; end
        end
        check("reboot_len", 64'(c), 64'(BOOT_TIME));
        check("reboot_no_done", 64'(fd), 64'h0);

        // Byte 2 = 0x00 with all ACKs: rejected only with the frame check.
`ifdef PSX_FRAME_CHECK_EN
        exp_p0 = 1'b0; exp_b0 = 16'hFFFF; exp_m0 = 8'h00;
`else
        exp_p0 = 1'b1; exp_b0 = 16'hFEFF; exp_m0 = 8'h41;
`endif
        wait_done(3000, ok);
        check("fc_done_seen", 64'(ok), 64'h1);
        check("fc_frame_port", 64'(frame_port), 64'h0);
        check("fc_present", 64'(present[0]), 64'(exp_p0));
        check("fc_button", 64'(button_state[15:0]), 64'(exp_b0));
        check("fc_mode", 64'(mode_id[7:0]), 64'(exp_m0));

        // ID 0x40: ID[3:0]=0 still gives a 5-byte frame.
        wait_done(3000, ok);
        check("id40_done_seen", 64'(ok), 64'h1);
        check("id40_frame_port", 64'(frame_port), 64'h1);
        check("id40_ncmd", 64'(ncmd), 64'd5);
        check("id40_present", 64'(present[1]), 64'h1);
        check("id40_button", 64'(button_state[31:16]), 64'hABCD);
        check("id40_mode", 64'(mode_id[15:8]), 64'h40);
        check("id40_stick", 64'(stick_state[63:32]), 64'h8080_8080);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
